// File: rtl/counter_ctrl_receiver_pkg.sv
// Shared definitions for the counter control receiver: FSM states, error bit
// positions, default count range and the range helper.
package counter_ctrl_receiver_pkg;

  localparam int MIN_VAL_DEF = 1;
  localparam int MAX_VAL_DEF = 12;
  localparam int WRAP_W_DEF  = 8;

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  typedef enum logic [1:0] {
    UNSYNC = ST_UNSYNC,
    SYNC   = ST_SYNC,
    FAULT  = ST_FAULT
  } state_e;

  localparam int ERR_RANGE    = 0;
  localparam int ERR_OVERRUN  = 1;
  localparam int ERR_MISMATCH = 2;

  function automatic logic in_range(input logic [3:0] v,
                                    input logic [3:0] lo,
                                    input logic [3:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/counter_ctrl_receiver_checker.sv
// Error detection and UNSYNC/SYNC/FAULT state machine for the receiver.
// Flags and state are registered; wrap_hit is a same-cycle qualifier for the top.
module ctrl_checker
  import counter_ctrl_receiver_pkg::*;
#(
  parameter int MIN_VAL = MIN_VAL_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       c_enable,
  input  logic       c_load,
  input  logic [3:0] c_d,
  input  logic [3:0] q_ref,
  input  logic [3:0] count,
  input  logic       clr_err,
  output logic       sync,
  output logic       fault,
  output logic [2:0] err_flags,
  output logic       wrap_hit
);

  localparam logic [3:0] MIN4 = 4'(MIN_VAL);
  localparam logic [3:0] MAX4 = 4'(MAX_VAL);

  state_e     state_q, state_d;
  logic       first_q, first_d;
  logic [2:0] err_q, err_d;
  logic [2:0] new_err_s;
  logic       wrap_hit_s;

  // Next-state, error detection and legal-wrap qualification
  always_comb begin
    state_d    = state_q;
    first_d    = 1'b0;
    new_err_s  = 3'b000;
    wrap_hit_s = 1'b0;
    case (state_q)
      UNSYNC: begin
        if (c_load) begin
          if (in_range(c_d, MIN4, MAX4)) begin
            state_d = SYNC;
            first_d = 1'b1;
          end else begin
            new_err_s[ERR_RANGE] = 1'b1;
          end
        end else begin
          state_d = UNSYNC;
        end
      end
      SYNC: begin
        new_err_s[ERR_RANGE]    = c_load && !in_range(c_d, MIN4, MAX4);
        new_err_s[ERR_OVERRUN]  = c_enable && !c_load && (count == MAX4);
        // q_ref lags our count by one cycle right after entry, so skip it once
        new_err_s[ERR_MISMATCH] = !first_q && (q_ref != count);
        wrap_hit_s = c_enable && c_load && (c_d == MIN4) && (count == MAX4);
        if (new_err_s != 3'b000) begin
          state_d = FAULT;
        end else begin
          state_d = SYNC;
        end
      end
      FAULT: begin
        if (clr_err) begin
          state_d = UNSYNC;
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        state_d = UNSYNC;
      end
    endcase
    if (clr_err) begin
      err_d = new_err_s;
    end else begin
      err_d = err_q | new_err_s;
    end
  end

  // State, first-cycle marker and sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UNSYNC;
      first_q <= 1'b0;
      err_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign sync      = (state_q == SYNC);
  assign fault     = (state_q == FAULT);
  assign err_flags = err_q;
  assign wrap_hit  = wrap_hit_s;

endmodule

// File: rtl/counter_ctrl_receiver.sv
// Receiver side of a counter control link: tracks the initiator's count locally,
// counts legal wraps and flags protocol errors through ctrl_checker.
module counter_ctrl_receiver
  import counter_ctrl_receiver_pkg::*;
#(
  parameter int MIN_VAL = MIN_VAL_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF,
  parameter int WRAP_W  = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_enable,
  input  logic              c_load,
  input  logic [3:0]        c_d,
  input  logic [3:0]        q_ref,
  input  logic              clr_err,
  output logic [3:0]        count,
  output logic              sync,
  output logic [2:0]        err_flags,
  output logic              fault,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  logic [3:0]        count_q, count_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              wrap_hit_s;

  ctrl_checker #(
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL)
  ) u_checker (
    .clk      (clk),
    .reset_n  (reset_n),
    .c_enable (c_enable),
    .c_load   (c_load),
    .c_d      (c_d),
    .q_ref    (q_ref),
    .count    (count_q),
    .clr_err  (clr_err),
    .sync     (sync),
    .fault    (fault),
    .err_flags(err_flags),
    .wrap_hit (wrap_hit_s)
  );

  // Local counter (load beats enable) and saturating wrap counter
  always_comb begin
    if (c_load) begin
      count_d = c_d;
    end else if (c_enable) begin
      count_d = count_q + 4'd1;
    end else begin
      count_d = count_q;
    end
    if (wrap_hit_s && (wrap_q != WRAP_MAX)) begin
      wrap_d = wrap_q + WRAP_ONE;
    end else begin
      wrap_d = wrap_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 4'd0;
      wrap_q  <= {WRAP_W{1'b0}};
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count    = count_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_counter_ctrl_receiver.sv
// Scoreboard bench for counter_ctrl_receiver: directed steps push expected
// outputs, a negedge monitor pops and compares them one cycle later.
module tb_counter_ctrl_receiver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       c_enable = 1'b0;
  logic       c_load = 1'b0;
  logic [3:0] c_d = 4'd0;
  logic [3:0] q_ref = 4'd0;
  logic       clr_err = 1'b0;
  logic [3:0] count;
  logic       sync;
  logic [2:0] err_flags;
  logic       fault;
  logic [7:0] wrap_cnt;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int         tgt;
    logic [16:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  counter_ctrl_receiver #(.MIN_VAL(1), .MAX_VAL(12), .WRAP_W(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .c_enable (c_enable),
    .c_load   (c_load),
    .c_d      (c_d),
    .q_ref    (q_ref),
    .clr_err  (clr_err),
    .count    (count),
    .sync     (sync),
    .err_flags(err_flags),
    .fault    (fault),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got count=%0d sync=%b err=%b fault=%b wrap=%0d, want count=%0d sync=%b err=%b fault=%b wrap=%0d",
               nm, act[16:13], act[12], act[11:9], act[8], act[7:0],
               exp[16:13], exp[12], exp[11:9], exp[8], exp[7:0]);
    end
  endtask

  function automatic logic [16:0] pack(input logic [3:0] c, input logic s,
                                       input logic [2:0] e, input logic f,
                                       input logic [7:0] w);
    return {c, s, e, f, w};
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected after the next edge
  task automatic step(input logic en, input logic ld, input logic [3:0] d,
                      input logic [3:0] qr, input logic clr,
                      input logic [3:0] ec, input logic es, input logic [2:0] ee,
                      input logic ef, input logic [7:0] ew, input string nm);
    exp_t e;
    @(negedge clk);
    c_enable = en;
    c_load   = ld;
    c_d      = d;
    q_ref    = qr;
    clr_err  = clr;
    e.tgt  = cyc + 1;
    e.exp  = pack(ec, es, ee, ef, ew);
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the scoreboard head each negedge
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
        mon_e = sb.pop_front();
        if (mon_e.tgt < cyc) begin
          tests_run++;
          fails++;
          $display("FAIL %s: check slot missed, got cycle %0d want cycle %0d", mon_e.name, cyc, mon_e.tgt);
        end else begin
          check(mon_e.name, {count, sync, err_flags, fault, wrap_cnt}, mon_e.exp);
        end
      end
    end
  end

  initial begin
    logic [7:0] w;
    #3;
    check("reset_init", {count, sync, err_flags, fault, wrap_cnt}, pack(4'd0, 1'b0, 3'b000, 1'b0, 8'd0));
    @(negedge clk);
    reset_n = 1'b1;

    // First legal load enters SYNC, then count up to MAX with q_ref tracking
    step(1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 4'd1, 1'b1, 3'b000, 1'b0, 8'd0, "first_load");
    for (int v = 2; v <= 12; v++)
      step(1'b1, 1'b0, 4'd0, 4'(v - 1), 1'b0, 4'(v), 1'b1, 3'b000, 1'b0, 8'd0, "count_up");
    step(1'b1, 1'b1, 4'd1, 4'd12, 1'b0, 4'd1, 1'b1, 3'b000, 1'b0, 8'd1, "wrap_first");

    // 299 more wraps: wrap_cnt saturates at 255
    w = 8'd1;
    for (int k = 2; k <= 300; k++) begin
      step(1'b0, 1'b1, 4'd12, 4'd1, 1'b0, 4'd12, 1'b1, 3'b000, 1'b0, w, "load_max");
      w = (k > 255) ? 8'd255 : 8'(k);
      step(1'b1, 1'b1, 4'd1, 4'd12, 1'b0, 4'd1, 1'b1, 3'b000, 1'b0, w, "wrap_sat");
    end

    // Overrun at MAX, FAULT keeps counting, clr_err returns to UNSYNC
    step(1'b0, 1'b1, 4'd12, 4'd1, 1'b0, 4'd12, 1'b1, 3'b000, 1'b0, 8'd255, "load_12");
    step(1'b1, 1'b0, 4'd0, 4'd12, 1'b0, 4'd13, 1'b0, 3'b010, 1'b1, 8'd255, "overrun");
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd14, 1'b0, 3'b010, 1'b1, 8'd255, "fault_count");
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd14, 1'b0, 3'b000, 1'b0, 8'd255, "fault_clear");

    // UNSYNC range errors; set beats clear; free counting wraps mod 16
    step(1'b0, 1'b1, 4'd14, 4'd0, 1'b0, 4'd14, 1'b0, 3'b001, 1'b0, 8'd255, "unsync_range");
    step(1'b0, 1'b1, 4'd14, 4'd0, 1'b1, 4'd14, 1'b0, 3'b001, 1'b0, 8'd255, "set_beats_clr");
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd14, 1'b0, 3'b000, 1'b0, 8'd255, "unsync_clr");
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd15, 1'b0, 3'b000, 1'b0, 8'd255, "unsync_count");
    step(1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 4'd0, 1'b0, 3'b000, 1'b0, 8'd255, "mod16_roll");
    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 3'b001, 1'b0, 8'd255, "below_min");
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 1'b0, 3'b000, 1'b0, 8'd255, "clr2");
    step(1'b0, 1'b1, 4'd12, 4'd0, 1'b0, 4'd12, 1'b1, 3'b000, 1'b0, 8'd255, "load_max_ok");
    step(1'b0, 1'b1, 4'd13, 4'd12, 1'b0, 4'd13, 1'b0, 3'b001, 1'b1, 8'd255, "sync_range");
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd13, 1'b0, 3'b000, 1'b0, 8'd255, "clr3");

    // Mismatch suppressed in first SYNC cycle, caught in the next
    step(1'b0, 1'b1, 4'd6, 4'd0, 1'b0, 4'd6, 1'b1, 3'b000, 1'b0, 8'd255, "load_6");
    step(1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 4'd6, 1'b1, 3'b000, 1'b0, 8'd255, "mm_suppressed");
    step(1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 4'd6, 1'b0, 3'b100, 1'b1, 8'd255, "mismatch");
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd6, 1'b0, 3'b000, 1'b0, 8'd255, "mm_clear");

    // Overrun and mismatch together
    step(1'b0, 1'b1, 4'd11, 4'd0, 1'b0, 4'd11, 1'b1, 3'b000, 1'b0, 8'd255, "load_11");
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd12, 1'b1, 3'b000, 1'b0, 8'd255, "up_12");
    step(1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 4'd13, 1'b0, 3'b110, 1'b1, 8'd255, "multi_err");
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd13, 1'b0, 3'b000, 1'b0, 8'd255, "clr4");

    // Asynchronous reset mid-cycle while in SYNC at count 7
    step(1'b0, 1'b1, 4'd7, 4'd0, 1'b0, 4'd7, 1'b1, 3'b000, 1'b0, 8'd255, "load_7");
    @(negedge clk);
    c_enable = 1'b0;
    c_load   = 1'b0;
    q_ref    = 4'd7;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", {count, sync, err_flags, fault, wrap_cnt}, pack(4'd0, 1'b0, 3'b000, 1'b0, 8'd0));
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 4'd1, 1'b0, 3'b000, 1'b0, 8'd0, "post_rst_unsync");
    step(1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 3'b000, 1'b0, 8'd0, "post_rst_load");
    step(1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 4'd4, 1'b1, 3'b000, 1'b0, 8'd0, "post_rst_up1");
    step(1'b1, 1'b0, 4'd0, 4'd4, 1'b0, 4'd5, 1'b1, 3'b000, 1'b0, 8'd0, "post_rst_up2");

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      tests_run++;
      fails++;
      $display("FAIL drain: got %0d pending checks, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/counter_ctrl_receiver.md
COUNTER_CTRL_RECEIVER -- requirements
Module: counter_ctrl_receiver

Interface
REQ-001 Parameter MIN_VAL, default 1: lowest legal count value.
REQ-002 Parameter MAX_VAL, default 12: highest legal count value; MIN_VAL < MAX_VAL <= 15.
REQ-003 Parameter WRAP_W, default 8: width of the wrap counter.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 c_enable  input  1: count-enable from the initiator.
REQ-007 c_load  input  1: load strobe from the initiator.
REQ-008 c_d  input  4: load value, valid when c_load=1.
REQ-009 q_ref  input  4: initiator's registered count, compared against local count.
REQ-010 clr_err  input  1: clears sticky error flags and leaves FAULT.
REQ-011 count  output  4: local 4-bit counter value.
REQ-012 sync  output  1: high while in SYNC state.
REQ-013 err_flags  output  3: sticky errors; bit0 RANGE, bit1 OVERRUN, bit2 MISMATCH.
REQ-014 fault  output  1: high while in FAULT state.
REQ-015 wrap_cnt  output  WRAP_W: number of legal wraps since reset.

Function
REQ-016 Local counter: c_load=1 -> count<=c_d; else c_enable=1 -> count<=count+1 modulo 16; else hold; load has priority over enable in every state.
REQ-017 FSM states UNSYNC, SYNC, FAULT; outputs sync and fault are decoded from state and are never high together.
REQ-018 UNSYNC: c_load with MIN_VAL<=c_d<=MAX_VAL -> SYNC next cycle; c_load with c_d out of range sets err_flags[0] and stays UNSYNC; no other checks active.
REQ-019 SYNC, RANGE error: c_load with c_d outside [MIN_VAL,MAX_VAL] sets err_flags[0].
REQ-020 SYNC, OVERRUN error: c_enable=1, c_load=0, count==MAX_VAL sets err_flags[1] (initiator missed its wrap load).
REQ-021 SYNC, MISMATCH error: q_ref != count sampled at a rising edge sets err_flags[2]; check is suppressed in the first SYNC cycle after entry.
REQ-022 Any error detected in SYNC -> FAULT at the same edge that sets the flag.
REQ-023 Legal wrap: in SYNC, c_enable=1, c_load=1, c_d==MIN_VAL, count==MAX_VAL -> wrap_cnt+1, saturating at all-ones.
REQ-024 FAULT: counter keeps following REQ-016; no new checks; clr_err=1 -> all err_flags cleared and state UNSYNC next cycle.
REQ-025 clr_err in UNSYNC or SYNC clears err_flags without state change; if an error is detected in the same cycle, the new error's bit is set (set wins over clear).
REQ-026 err_flags bits are independent; multiple bits may set in one cycle.
REQ-027 No output is combinationally dependent on any input; all outputs are registered or decoded from registered state.

Reset
REQ-028 reset_n low asynchronously forces count=0, state UNSYNC (sync=0, fault=0), err_flags=0, wrap_cnt=0.
REQ-029 Reset mid-operation (any state, any count) discards all history; after release the block waits for a legal load per REQ-018.
REQ-030 Release of reset_n is assumed synchronous to clk by the integrator; the block adds no internal synchronizer.

Structure
REQ-031 Shared package holds the FSM state enum (UNSYNC, SYNC, FAULT), err_flags bit-index constants and MIN_VAL/MAX_VAL defaults.
REQ-032 One sub-module, ctrl_checker, contains the error detection logic and the FSM; local counter and wrap counter stay in the top level.

Verification
REQ-033 Reset, then c_load=1, c_d=1 -> count=1, sync=1 next cycle; err_flags=000.
REQ-034 From count=12 in SYNC: c_enable=1, c_load=1, c_d=1 -> count=1, wrap_cnt increments by 1, no error; run 300 wraps with WRAP_W=8 -> wrap_cnt saturates at 255.
REQ-035 From count=12 in SYNC: c_enable=1, c_load=0 -> err_flags=010, fault=1, count=13.
REQ-036 In SYNC, drive q_ref=5 while count=6 -> err_flags=100, fault=1; assert clr_err=1 -> err_flags=000, state UNSYNC next cycle.
REQ-037 In UNSYNC, c_load=1, c_d=14 -> err_flags=001, sync stays 0; same cycle clr_err=1 -> err_flags still 001.
REQ-038 In SYNC at count=7, pulse reset_n low between clock edges -> count=0, sync=0, err_flags=000, wrap_cnt=0 immediately, before the next edge.
